// File: rtl/muntjac_perf_counters.sv
// Machine-mode counter / HPM CSR unit: owns mcycle, minstret, mhpmcounters, mhpmevents and
// mcountinhibit, checks access privilege and answers every CSR request one cycle later.
module muntjac_perf_counters #(
    parameter int unsigned NumHpm    = 4,
    parameter int unsigned HpmWidth  = 40,
    parameter int unsigned NumEvents = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    input  logic [11:0]          req_addr_i,
    input  logic [1:0]           req_op_i,
    input  logic [63:0]          req_wdata_i,
    input  logic [1:0]           priv_i,
    input  logic [31:0]          mcounteren_i,
    input  logic [31:0]          scounteren_i,
    input  logic                 instret_i,
    input  logic [NumEvents-1:0] events_i,
    output logic                 resp_valid_o,
    output logic [63:0]          resp_rdata_o,
    output logic                 resp_illegal_o
);

    localparam int unsigned EvWidth  = $clog2(NumEvents + 1);
    localparam int unsigned HpmSlots = (NumHpm > 0) ? NumHpm : 1;
    localparam logic [31:0] InhibitMask = 32'((64'd1 << (3 + NumHpm)) - 64'd1) & ~32'd2;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Handshake: there is no ready; every cycle with req_valid_i high is accepted, and
    // resp_valid_o is exactly req_valid_i delayed by one cycle with its rdata/illegal.

    logic [63:0]         r_mcycle;
    logic [63:0]         r_minstret;
    logic [HpmWidth-1:0] r_hpm     [HpmSlots];
    logic [EvWidth-1:0]  r_event   [HpmSlots];
    logic [31:0]         r_inhibit;

    logic                r_resp_valid;
    logic [63:0]         r_resp_rdata;
    logic                r_resp_illegal;

    logic [4:0]          w_idx;
    logic                w_is_mctr;
    logic                w_is_uctr;
    logic                w_is_event;
    logic                w_is_inhibit;
    logic                w_is_machine;
    logic                w_nz_modify;
    logic                w_shadow_ok;
    logic                w_legal;
    logic                w_we;
    logic [63:0]         w_old;
    logic [63:0]         w_new;
    logic [HpmSlots-1:0] w_hit;

    assign w_idx        = req_addr_i[4:0];
    // 0xB00/0xC00 blocks minus index 1 (mtime/time live elsewhere); *H halves never match.
    assign w_is_mctr    = (req_addr_i[11:5] == 7'h58) && (w_idx != 5'd1);
    assign w_is_uctr    = (req_addr_i[11:5] == 7'h60) && (w_idx != 5'd1);
    assign w_is_event   = (req_addr_i[11:5] == 7'h19) && (w_idx >= 5'd3);
    assign w_is_inhibit = (req_addr_i == 12'h320);
    assign w_is_machine = w_is_mctr || w_is_event || w_is_inhibit;
    assign w_nz_modify  = (req_op_i != OP_READ) && (req_wdata_i != 64'd0);

    always_comb begin
        w_shadow_ok = 1'b0;
        case (priv_i)
            PRIV_M:  w_shadow_ok = 1'b1;
            PRIV_S:  w_shadow_ok = mcounteren_i[w_idx];
            PRIV_U:  w_shadow_ok = mcounteren_i[w_idx] & scounteren_i[w_idx];
            default: w_shadow_ok = 1'b0;
        endcase
    end

    assign w_legal = (w_is_machine && (priv_i == PRIV_M)) ||
                     (w_is_uctr && !w_nz_modify && w_shadow_ok);

    // Set/clear with a zero operand leaves the CSR untouched so the increment survives.
    assign w_we = req_valid_i && w_legal && w_is_machine &&
                  ((req_op_i == OP_WRITE) || (req_wdata_i != 64'd0));

    always_comb begin
        w_old = 64'd0;
        if (w_is_mctr || w_is_uctr) begin
            if (w_idx == 5'd0) begin
                w_old = r_mcycle;
            end else if (w_idx == 5'd2) begin
                w_old = r_minstret;
            end else begin
                for (int k = 0; k < NumHpm; k++) begin
                    if (w_idx == 5'(3 + k)) begin
                        w_old = 64'(r_hpm[k]);
                    end
                end
            end
        end else if (w_is_event) begin
            for (int k = 0; k < NumHpm; k++) begin
                if (w_idx == 5'(3 + k)) begin
                    w_old = 64'(r_event[k]);
                end
            end
        end else if (w_is_inhibit) begin
            w_old = 64'(r_inhibit);
        end
    end

    always_comb begin
        w_new = 64'd0;
        case (req_op_i)
            OP_WRITE: w_new = req_wdata_i;
            OP_SET:   w_new = w_old | req_wdata_i;
            default:  w_new = w_old & ~req_wdata_i;
        endcase
    end

    // Selector values 0 and above NumEvents match no loop iteration, so they never count.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NumHpm; k++) begin
            for (int e = 1; e <= NumEvents; e++) begin
                if ((r_event[k] == EvWidth'(e)) && events_i[e-1]) begin
                    w_hit[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
            r_inhibit  <= 32'd0;
            for (int k = 0; k < HpmSlots; k++) begin
                r_hpm[k]   <= '0;
                r_event[k] <= '0;
            end
        end else begin
            if (w_we && w_is_mctr && (w_idx == 5'd0)) begin
                r_mcycle <= w_new;
            end else if (!r_inhibit[0]) begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_we && w_is_mctr && (w_idx == 5'd2)) begin
                r_minstret <= w_new;
            end else if (instret_i && !r_inhibit[2]) begin
                r_minstret <= r_minstret + 64'd1;
            end

            for (int k = 0; k < NumHpm; k++) begin
                if (w_we && w_is_mctr && (w_idx == 5'(3 + k))) begin
                    r_hpm[k] <= w_new[HpmWidth-1:0];
                end else if (w_hit[k] && !r_inhibit[3 + k]) begin
                    r_hpm[k] <= r_hpm[k] + HpmWidth'(1);
                end

                if (w_we && w_is_event && (w_idx == 5'(3 + k))) begin
                    r_event[k] <= w_new[EvWidth-1:0];
                end
            end

            if (w_we && w_is_inhibit) begin
                r_inhibit <= w_new[31:0] & InhibitMask;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= 64'd0;
            r_resp_illegal <= 1'b0;
        end else begin
            r_resp_valid   <= req_valid_i;
            r_resp_rdata   <= (req_valid_i && w_legal) ? w_old : 64'd0;
            r_resp_illegal <= req_valid_i && !w_legal;
        end
    end

    assign resp_valid_o   = r_resp_valid;
    assign resp_rdata_o   = r_resp_rdata;
    assign resp_illegal_o = r_resp_illegal;

endmodule

// File: tb/tb_muntjac_perf_counters.sv
// Bench for muntjac_perf_counters: an address-range model of the counter CSRs predicts every
// response; directed scenarios also pin a few responses to hand-computed literals.
module tb_muntjac_perf_counters;

  localparam int NumHpm    = 4;
  localparam int HpmWidth  = 40;
  localparam int NumEvents = 8;
  localparam logic [63:0] HPM_MASK = (64'd1 << HpmWidth) - 64'd1;
  localparam logic [63:0] EV_MASK  = 64'd15;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 req_valid_i = 1'b0;
  logic [11:0]          req_addr_i = '0;
  logic [1:0]           req_op_i = '0;
  logic [63:0]          req_wdata_i = '0;
  logic [1:0]           priv_i = 2'b11;
  logic [31:0]          mcounteren_i = '0;
  logic [31:0]          scounteren_i = '0;
  logic                 instret_i = 1'b0;
  logic [NumEvents-1:0] events_i = '0;
  logic                 resp_valid_o;
  logic [63:0]          resp_rdata_o;
  logic                 resp_illegal_o;

  logic [1:0]  cur_priv = 2'b11;
  logic [31:0] cur_mcen = '0;
  logic [31:0] cur_scen = '0;

  int checks = 0;
  int failures = 0;

  // expected entry: {valid, illegal, rdata}
  logic [65:0] exp_q[$];
  logic [65:0] cmp_e;

  logic [63:0] m_ctr[32];
  logic [63:0] m_evt[32];
  logic [31:0] m_inh;

  muntjac_perf_counters #(
    .NumHpm(NumHpm),
    .HpmWidth(HpmWidth),
    .NumEvents(NumEvents)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_addr_i(req_addr_i),
    .req_op_i(req_op_i),
    .req_wdata_i(req_wdata_i),
    .priv_i(priv_i),
    .mcounteren_i(mcounteren_i),
    .scounteren_i(scounteren_i),
    .instret_i(instret_i),
    .events_i(events_i),
    .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o),
    .resp_illegal_o(resp_illegal_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_ctr[i] = 64'd0;
      m_evt[i] = 64'd0;
    end
    m_inh = 32'd0;
  endtask

  // ---------------- model ----------------
  function automatic logic [31:0] inh_mask();
    logic [31:0] m;
    m = 32'h5;
    for (int i = 3; i < 3 + NumHpm; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic m_legal(input int a, input logic [1:0] op, input logic [63:0] wd,
                                   input logic [1:0] pr);
    int idx;
    logic mach;
    logic shad;
    mach = (a == 'hB00) || (a == 'hB02) || (a >= 'hB03 && a <= 'hB1F) ||
           (a >= 'h323 && a <= 'h33F) || (a == 'h320);
    shad = (a == 'hC00) || (a == 'hC02) || (a >= 'hC03 && a <= 'hC1F);
    if (mach) return pr == 2'b11;
    if (!shad) return 1'b0;
    if (op != 2'b00 && wd != 64'd0) return 1'b0;
    idx = a - 'hC00;
    if (pr == 2'b11) return 1'b1;
    if (pr == 2'b01) return cur_mcen[idx];
    if (pr == 2'b00) return cur_mcen[idx] && cur_scen[idx];
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_read(input int a);
    int idx;
    if ((a >= 'hB00 && a <= 'hB1F) || (a >= 'hC00 && a <= 'hC1F)) begin
      idx = a % 32;
      return (idx < 3 + NumHpm) ? m_ctr[idx] : 64'd0;
    end
    if (a >= 'h323 && a <= 'h33F) begin
      idx = a - 'h320;
      return (idx < 3 + NumHpm) ? m_evt[idx] : 64'd0;
    end
    if (a == 'h320) return 64'(m_inh);
    return 64'd0;
  endfunction

  task automatic model_step();
    int a;
    int idx;
    int ev;
    logic legal;
    logic [63:0] old;
    logic [63:0] nv;
    a = int'(req_addr_i);
    legal = m_legal(a, req_op_i, req_wdata_i, cur_priv);
    old = m_read(a);
    exp_q.push_back({req_valid_i, req_valid_i && !legal, (req_valid_i && legal) ? old : 64'd0});
    if (!m_inh[0]) m_ctr[0] = m_ctr[0] + 64'd1;
    if (instret_i && !m_inh[2]) m_ctr[2] = m_ctr[2] + 64'd1;
    for (int k = 3; k < 3 + NumHpm; k++) begin
      ev = int'(m_evt[k]);
      if (ev >= 1 && ev <= NumEvents && !m_inh[k] && events_i[ev-1])
        m_ctr[k] = (m_ctr[k] + 64'd1) & HPM_MASK;
    end
    if (req_valid_i && legal && req_op_i != 2'b00 && (req_op_i == 2'b01 || req_wdata_i != 64'd0)) begin
      if (req_op_i == 2'b01) nv = req_wdata_i;
      else if (req_op_i == 2'b10) nv = old | req_wdata_i;
      else nv = old & ~req_wdata_i;
      if (a >= 'hB00 && a <= 'hB1F) begin
        idx = a - 'hB00;
        if (idx == 0 || idx == 2) m_ctr[idx] = nv;
        else if (idx < 3 + NumHpm) m_ctr[idx] = nv & HPM_MASK;
      end else if (a >= 'h323 && a <= 'h33F) begin
        idx = a - 'h320;
        if (idx < 3 + NumHpm) m_evt[idx] = nv & EV_MASK;
      end else if (a == 'h320) begin
        m_inh = nv[31:0] & inh_mask();
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_and_step(input logic v, input logic [11:0] a, input logic [1:0] op,
                                input logic [63:0] wd, input logic ir, input logic [7:0] ev);
    req_valid_i  = v;
    req_addr_i   = a;
    req_op_i     = op;
    req_wdata_i  = wd;
    instret_i    = ir;
    events_i     = ev;
    priv_i       = cur_priv;
    mcounteren_i = cur_mcen;
    scounteren_i = cur_scen;
    model_step();
  endtask

  task automatic tick(input logic v, input logic [11:0] a, input logic [1:0] op,
                      input logic [63:0] wd, input logic ir, input logic [7:0] ev);
    @(negedge clk_i);
    drive_and_step(v, a, op, wd, ir, ev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 12'h0, 2'b00, 64'd0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [11:0] a);
    tick(1'b1, a, 2'b00, 64'd0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
    tick(1'b1, a, op, wd, 1'b0, 8'h00);
  endtask

  task automatic pulse(input logic [7:0] ev);
    tick(1'b0, 12'h0, 2'b00, 64'd0, 1'b0, ev);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic expect_resp(input string name, input logic [63:0] rdata, input logic ill);
    @(posedge clk_i);
    #2;
    chk({name, "_valid"}, 64'(resp_valid_o), 64'd1);
    chk({name, "_illegal"}, 64'(resp_illegal_o), 64'(ill));
    chk({name, "_rdata"}, resp_rdata_o, rdata);
  endtask

  task automatic expect_ill(input string name, input logic ill);
    @(posedge clk_i);
    #2;
    chk({name, "_valid"}, 64'(resp_valid_o), 64'd1);
    chk({name, "_illegal"}, 64'(resp_illegal_o), 64'(ill));
  endtask

  always @(posedge clk_i) begin
    #1;
    if (!rst_i && exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      chk("model_valid", 64'(resp_valid_o), 64'(cmp_e[65]));
      if (cmp_e[65]) begin
        chk("model_illegal", 64'(resp_illegal_o), 64'(cmp_e[64]));
        chk("model_rdata", resp_rdata_o, cmp_e[63:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    chk("reset_valid", 64'(resp_valid_o), 64'd0);
    chk("reset_rdata", resp_rdata_o, 64'd0);
    chk("reset_illegal", 64'(resp_illegal_o), 64'd0);

    @(negedge clk_i);
    rst_i = 1'b0;
    drive_and_step(1'b0, 12'h0, 2'b00, 64'd0, 1'b0, 8'h00);
    idle(9);
    rd(12'hB00);
    expect_resp("mcycle_after_10", 64'd10, 1'b0);

    // write precedence over same-cycle retire, then wrap of minstret
    tick(1'b1, 12'hB02, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h00);
    expect_resp("minstret_write_old", 64'd0, 1'b0);
    tick(1'b1, 12'hB02, 2'b00, 64'd0, 1'b1, 8'h00);
    expect_resp("minstret_written", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    rd(12'hB02);
    expect_resp("minstret_wrapped", 64'd0, 1'b0);

    // hpm3 counts event 2; inhibited for two of five pulses
    wr(12'h323, 2'b01, 64'd2);
    pulse(8'h02);
    pulse(8'h02);
    wr(12'h320, 2'b10, 64'h8);
    pulse(8'h02);
    pulse(8'h02);
    wr(12'h320, 2'b11, 64'h8);
    pulse(8'h02);
    rd(12'hB03);
    expect_resp("hpm3_count", 64'd3, 1'b0);
    wr(12'hB03, 2'b01, (64'd1 << 40) - 64'd1);
    pulse(8'h02);
    rd(12'hB03);
    expect_resp("hpm3_wrap", 64'd0, 1'b0);

    // out-of-range selector masked and never counts; selector 8 uses the top event bit
    wr(12'h324, 2'b01, 64'hFF);
    rd(12'h324);
    expect_resp("mhpmevent4_mask", 64'hF, 1'b0);
    wr(12'h325, 2'b01, 64'd8);
    pulse(8'hFF);
    pulse(8'h80);
    rd(12'hB04);
    expect_resp("hpm4_no_count", 64'd0, 1'b0);
    rd(12'hB05);
    expect_resp("hpm5_event8", 64'd2, 1'b0);

    // user / supervisor shadow access
    cur_priv = 2'b00;
    cur_mcen = 32'h1;
    cur_scen = 32'h0;
    rd(12'hC00);
    expect_resp("u_cycle_no_scen", 64'd0, 1'b1);
    cur_scen = 32'h1;
    rd(12'hC00);
    expect_ill("u_cycle_scen", 1'b0);
    wr(12'hB00, 2'b01, 64'd0);
    expect_ill("u_mcycle_write", 1'b1);
    cur_priv = 2'b01;
    cur_mcen = 32'h0;
    rd(12'hC00);
    expect_resp("s_cycle_no_mcen", 64'd0, 1'b1);
    cur_mcen = 32'h8;
    rd(12'hC03);
    expect_ill("s_hpm3_mcen", 1'b0);
    cur_priv = 2'b11;

    // illegal addresses and read-only shadows
    wr(12'hC02, 2'b01, 64'd5);
    expect_resp("write_shadow", 64'd0, 1'b1);
    rd(12'hB80);
    expect_resp("mcycleh", 64'd0, 1'b1);
    rd(12'hC01);
    expect_resp("time", 64'd0, 1'b1);
    rd(12'h7A0);
    expect_resp("other_addr", 64'd0, 1'b1);
    rd(12'hB01);
    expect_resp("mtime", 64'd0, 1'b1);
    wr(12'hC00, 2'b10, 64'd0);
    expect_ill("set_zero_shadow", 1'b0);
    rd(12'hB02);

    // unimplemented counter and inhibit mask
    wr(12'hB1F, 2'b01, 64'h55);
    expect_resp("hpm31_write", 64'd0, 1'b0);
    rd(12'hB1F);
    expect_resp("hpm31_read", 64'd0, 1'b0);
    wr(12'h320, 2'b01, 64'hFFFF_FFFF);
    rd(12'h320);
    expect_resp("inhibit_mask", 64'h7D, 1'b0);
    tick(1'b0, 12'h0, 2'b00, 64'd0, 1'b1, 8'hFF);
    rd(12'hB00);
    rd(12'hB00);
    rd(12'hB03);
    wr(12'h320, 2'b01, 64'd0);
    idle(2);
    rd(12'hB00);

    // reset while a response is pending drops it
    rd(12'hB00);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    chk("reset_drop_valid", 64'(resp_valid_o), 64'd0);
    chk("reset_drop_rdata", resp_rdata_o, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_and_step(1'b0, 12'h0, 2'b00, 64'd0, 1'b0, 8'h00);
    rd(12'hB00);
    expect_resp("mcycle_after_rereset", 64'd1, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muntjac_perf_counters.md
Name: muntjac_perf_counters

Overview:
- Machine-mode counter/performance-monitor CSR unit for the RV64 core.
- Sits directly downstream of the CSR address decode in the execute stage: receives decoded CSR accesses in the counter address space (CSR_CYCLE..CSR_HPMCOUNTER31, CSR_MCYCLE..CSR_MHPMCOUNTER31, CSR_MHPMEVENT3..31, CSR_MCOUNTINHIBIT).
- Owns the counter state, performs privilege checks and returns read data and an illegal flag one cycle later.

Parameters:
- NumHpm, 4, number of implemented hpmcounters (3 .. 3+NumHpm-1), range 0..29.
- HpmWidth, 40, implemented bits of each mhpmcounter, 1..64; upper bits read zero.
- NumEvents, 8, width of the event input bus; selector values 1..NumEvents are valid.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- req_valid_i  input  1  CSR access request this cycle
- req_addr_i  input  12  CSR address
- req_op_i  input  2  00 read, 01 write, 10 set, 11 clear
- req_wdata_i  input  64  write/set/clear operand
- priv_i  input  2  current privilege: 00 U, 01 S, 11 M
- mcounteren_i  input  32  mcounteren CSR value
- scounteren_i  input  32  scounteren CSR value
- instret_i  input  1  one instruction retired this cycle
- events_i  input  NumEvents  per-cycle event pulses
- resp_valid_o  output  1  response valid, exactly one cycle after req_valid_i
- resp_rdata_o  output  64  old CSR value (pre-write); 0 when illegal
- resp_illegal_o  output  1  access is illegal and raises an illegal-instruction exception

Behaviour:
- Reset (async, rst_i=1): mcycle, minstret, all mhpmcounter, mhpmevent and mcountinhibit = 0; resp_valid_o=0, resp_rdata_o=0, resp_illegal_o=0.
- Counter increment, each cycle unless inhibited:
  - mcycle +1 when mcountinhibit[0]=0.
  - minstret +1 when instret_i=1 and mcountinhibit[2]=0.
  - mhpmcounter k +1 when mcountinhibit[k]=0, mhpmevent k = e with 1<=e<=NumEvents, and events_i[e-1]=1.
  - Event values 0 or >NumEvents never count.
- Wrap: mcycle/minstret wrap 2^64-1 -> 0; hpmcounters wrap at 2^HpmWidth-1 -> 0.
- mcountinhibit: bits 0, 2 and 3..3+NumHpm-1 writable; bit 1 and all others hardwired 0.
- Write semantics: write = wdata, set = old|wdata, clear = old&~wdata. Set/clear with wdata=0 count as reads for legality.
- Precedence: a legal write to a counter in cycle N takes precedence over that cycle's increment; the new value is visible in cycle N+1 and the increment is lost.
- Address classes and legality:
  - CSR_MHPMEVENT*: new value masked to the low ceil(log2(NumEvents+1)) bits.
  - Machine counters (0xB00, 0xB02, 0xB03..0xB1F), mhpmevent (0x323..0x33F), mcountinhibit: priv_i must be M, else illegal.
  - 0xB01 (mtime) is illegal.
  - User shadows (0xC00, 0xC02, 0xC03..0xC1F): read-only, so any write/set/clear with nonzero operand is illegal.
  - User shadow reads: M always legal; S requires mcounteren_i[idx]; U requires mcounteren_i[idx] & scounteren_i[idx]; idx = addr[4:0].
  - 0xC01 (time) is illegal here; time is provided elsewhere.
  - All *H addresses (0xB80-0xB9F, 0xC80-0xC9F) are illegal (RV64).
  - Any other address is illegal.
- Unimplemented hpm indices (>=3+NumHpm): legal, read 0, writes ignored.
- Illegal access: no state change; resp_rdata_o=0, resp_illegal_o=1.
- Latency: response registered; resp_valid_o=req_valid_i delayed by one cycle. Back-to-back requests are accepted every cycle with no stall. A read in cycle N+1 of a counter written in cycle N returns the written value.
- Read data: the value at the request cycle, before that cycle's increment or write.
- Reset asserted mid-request: the pending response is dropped (resp_valid_o=0).

Test Plan:
- Reset then 10 idle cycles; M read 0xB00 -> resp next cycle, rdata=10 (±pipeline offset fixed by bench), illegal=0.
- M write 0xB02 = 0xFFFF_FFFF_FFFF_FFFF with instret_i=1 same cycle; retire again next cycle -> read minstret = 0, showing write precedence and wrap.
- mhpmevent3=2, events_i[1] pulsed 5 times, mcountinhibit[3]=1 for 2 of them -> mhpmcounter3=3. Then write 0xB03=2^40-1, one event -> reads 0.
- U-mode read 0xC00 with mcounteren=1, scounteren=0 -> illegal=1, rdata=0. Set scounteren=1 -> legal, correct cycle count. S-mode with mcounteren=0 -> illegal.
- Write 0xC02 (nonzero), access 0xB80, 0xC01 or 0x7A0 -> illegal=1 and counters unchanged. Set on 0xC00 with wdata=0 in M -> legal read.
- Write 0xB1F (unimplemented, NumHpm=4) = 0x55 -> legal, reads 0. Write mcountinhibit=0xFFFF_FFFF -> reads 0x7D.
